// File: rtl/dco_ctrl_pkg.sv
// Shared state encodings and default widths for the DCO sweep controller.
package dco_ctrl_pkg;

    localparam int DEFAULT_PHASE_INCREMENT_BITS = 28;
    localparam int DEFAULT_DWELL_BITS           = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/dco_dwell_counter.sv
// Loadable dwell down-counter; advances only on CE cycles and saturates at zero.
module dco_dwell_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             LOAD,
    input  logic             DEC,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic             ZERO
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (CE) begin
            if (LOAD) begin
                count <= LOAD_VALUE;
            end else if (DEC && (count != '0)) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign ZERO = (count == '0);

endmodule

// File: rtl/dco_sweep_controller.sv
// Steps the DCO phase increment from START_INC to STOP_INC, dwelling on each point
// and strobing POINT_DONE at the end of every dwell.
module dco_sweep_controller
    import dco_ctrl_pkg::*;
#(
    parameter int PHASE_INCREMENT_BITS = DEFAULT_PHASE_INCREMENT_BITS,
    parameter int DWELL_BITS           = DEFAULT_DWELL_BITS
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            CE,
    input  logic                            START,
    input  logic                            ABORT,
    input  logic [PHASE_INCREMENT_BITS-1:0] START_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0] STOP_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0] STEP_INC,
    input  logic [DWELL_BITS-1:0]           DWELL_CYCLES,
    output logic [PHASE_INCREMENT_BITS-1:0] INC_OUT,
    output logic                            INC_WE,
    output logic                            POINT_DONE,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int PIB = PHASE_INCREMENT_BITS;

    sweep_state_t    state, state_nxt;
    logic [PIB-1:0]  cur, cur_nxt;
    logic [PIB-1:0]  stop_reg, stop_nxt;
    logic [PIB-1:0]  step_reg, step_nxt;
    logic [DWELL_BITS-1:0] dwell_reg, dwell_nxt, dwell_load_value;
    logic [PIB-1:0]  inc_out_nxt;
    logic            inc_we_nxt, point_done_nxt, busy_nxt, done_nxt;
    logic            cnt_zero;
    logic [PIB:0]    next_sum;
    logic            sweep_end;

    // Zero dwell is treated as one cycle.
    assign dwell_load_value = (dwell_reg == '0) ? '0 : dwell_reg - DWELL_BITS'(1);

    // Extra bit keeps the carry so an overflowing step ends the sweep instead of wrapping.
    assign next_sum  = {1'b0, cur} + {1'b0, step_reg};
    assign sweep_end = (step_reg == '0) || (next_sum > {1'b0, stop_reg});

    dco_dwell_counter #(
        .WIDTH (DWELL_BITS)
    ) u_dwell_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .CE         (CE),
        .LOAD       (state == ST_LOAD),
        .DEC        (state == ST_DWELL),
        .LOAD_VALUE (dwell_load_value),
        .ZERO       (cnt_zero)
    );

    always_comb begin
        state_nxt      = state;
        cur_nxt        = cur;
        stop_nxt       = stop_reg;
        step_nxt       = step_reg;
        dwell_nxt      = dwell_reg;
        inc_out_nxt    = INC_OUT;
        inc_we_nxt     = 1'b0;
        point_done_nxt = 1'b0;
        busy_nxt       = BUSY;
        done_nxt       = DONE;

        if (ABORT) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        cur_nxt   = START_INC;
                        stop_nxt  = STOP_INC;
                        step_nxt  = STEP_INC;
                        dwell_nxt = DWELL_CYCLES;
                        done_nxt  = 1'b0;
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    inc_out_nxt = cur;
                    inc_we_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                    state_nxt   = ST_DWELL;
                end
                ST_DWELL: begin
                    if (cnt_zero) begin
                        point_done_nxt = 1'b1;
                        if (sweep_end) begin
                            state_nxt = ST_DONE;
                        end else begin
                            cur_nxt   = next_sum[PIB-1:0];
                            state_nxt = ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cur        <= '0;
            stop_reg   <= '0;
            step_reg   <= '0;
            dwell_reg  <= '0;
            INC_OUT    <= '0;
            INC_WE     <= 1'b0;
            POINT_DONE <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else if (CE) begin
            state      <= state_nxt;
            cur        <= cur_nxt;
            stop_reg   <= stop_nxt;
            step_reg   <= step_nxt;
            dwell_reg  <= dwell_nxt;
            INC_OUT    <= inc_out_nxt;
            INC_WE     <= inc_we_nxt;
            POINT_DONE <= point_done_nxt;
            BUSY       <= busy_nxt;
            DONE       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dco_sweep_controller.sv
// Bench for dco_sweep_controller: each sweep is checked cycle by cycle against a
// point list and timing schedule derived from the sweep rules.
module tb_dco_sweep_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CE = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [27:0] START_INC = '0;
    logic [27:0] STOP_INC = '0;
    logic [27:0] STEP_INC = '0;
    logic [15:0] DWELL_CYCLES = '0;
    logic [27:0] INC_OUT;
    logic        INC_WE;
    logic        POINT_DONE;
    logic        BUSY;
    logic        DONE;

    int          checks = 0;
    int          failures = 0;
    logic [27:0] model_inc = '0;

    always #5 CLK = ~CLK;

    dco_sweep_controller #(
        .PHASE_INCREMENT_BITS (28),
        .DWELL_BITS           (16)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CE           (CE),
        .START        (START),
        .ABORT        (ABORT),
        .START_INC    (START_INC),
        .STOP_INC     (STOP_INC),
        .STEP_INC     (STEP_INC),
        .DWELL_CYCLES (DWELL_CYCLES),
        .INC_OUT      (INC_OUT),
        .INC_WE       (INC_WE),
        .POINT_DONE   (POINT_DONE),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    // t counts CE edges since the accepting edge (t=0). A point lasts p=1+max(dwell,1)
    // CE cycles: WE after edge 1+k*p, POINT_DONE after edge (k+1)*p, DONE after n*p+1.
    task automatic run_sweep(input logic [27:0] s, input logic [27:0] e, input logic [27:0] st,
                             input logic [15:0] dw, input int ce_mode, input int abort_t,
                             input string name);
        longint      pts[$];
        longint      v;
        int          p, n, t, cyc, last_t, k;
        bit          ce_e, aborted, timed_out;
        logic [27:0] exp_out;
        logic        e_we, e_pd, e_busy, e_done;
        v = longint'(s);
        for (int i = 0; i < 64; i++) begin
            pts.push_back(v);
            if (st == 0 || v + longint'(st) > longint'(e)) break;
            v = v + longint'(st);
        end
        p = 1 + ((dw == 0) ? 1 : int'(dw));
        n = pts.size();
        last_t = (abort_t >= 0) ? abort_t + 4 : n * p + 1;
        t = -1;
        cyc = 0;
        timed_out = 0;
        exp_out = model_inc;
        @(negedge CLK);
        START_INC = s; STOP_INC = e; STEP_INC = st; DWELL_CYCLES = dw;
        START = 1'b1; ABORT = 1'b0;
        while (t < last_t && !timed_out) begin
            if (abort_t >= 0 && t + 1 == abort_t) begin
                CE = 1'b1; ABORT = 1'b1;
            end else begin
                ABORT = 1'b0;
                case (ce_mode)
                    0:       CE = 1'b1;
                    1:       CE = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    default: CE = 1'($urandom_range(0, 1));
                endcase
            end
            @(posedge CLK);
            ce_e = CE;
            #1;
            if (ce_e) t++;
            cyc++;
            aborted = (abort_t >= 0) && (t >= abort_t);
            if (t >= 0) begin
                if (aborted) begin
                    e_we = 0; e_pd = 0; e_busy = 0; e_done = 0;
                end else begin
                    e_we   = (t >= 1) && (((t - 1) % p) == 0) && (((t - 1) / p) < n);
                    e_pd   = (t >= p) && ((t % p) == 0) && ((t / p) <= n);
                    e_busy = (t >= 1) && (t <= n * p);
                    e_done = (t >= n * p + 1);
                    if (e_we) begin
                        k = (t - 1) / p;
                        exp_out = 28'(pts[k]);
                    end
                end
                checks += 5;
                if (INC_WE !== e_we) begin
                    failures++;
                    $display("FAIL %s t=%0d INC_WE got=%b exp=%b", name, t, INC_WE, e_we);
                end
                if (INC_OUT !== exp_out) begin
                    failures++;
                    $display("FAIL %s t=%0d INC_OUT got=%h exp=%h", name, t, INC_OUT, exp_out);
                end
                if (POINT_DONE !== e_pd) begin
                    failures++;
                    $display("FAIL %s t=%0d POINT_DONE got=%b exp=%b", name, t, POINT_DONE, e_pd);
                end
                if (BUSY !== e_busy) begin
                    failures++;
                    $display("FAIL %s t=%0d BUSY got=%b exp=%b", name, t, BUSY, e_busy);
                end
                if (DONE !== e_done) begin
                    failures++;
                    $display("FAIL %s t=%0d DONE got=%b exp=%b", name, t, DONE, e_done);
                end
            end
            @(negedge CLK);
            if (t >= 0) begin
                // Captured config must be immune to later input activity.
                START = (t + 1 <= n * p && !aborted) ? 1'($urandom_range(0, 1)) : 1'b0;
                START_INC = 28'($urandom); STOP_INC = 28'($urandom);
                STEP_INC = 28'($urandom); DWELL_CYCLES = 16'($urandom);
            end
            if (cyc > 4000) begin
                checks++; failures++; timed_out = 1;
                $display("FAIL %s timeout t=%0d exp_last=%0d", name, t, last_t);
            end
        end
        START = 1'b0; ABORT = 1'b0; CE = 1'b1;
        model_inc = exp_out;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        #1;
        checks++;
        if ({INC_OUT, INC_WE, POINT_DONE, BUSY, DONE} !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {INC_OUT, INC_WE, POINT_DONE, BUSY, DONE});
        end
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        model_inc = '0;
    endtask

    task automatic test_sweep_basic;
        run_sweep(28'd100, 28'd130, 28'd10, 16'd3, 0, -1, "basic");
    endtask

    task automatic test_stop_below_start;
        run_sweep(28'd200, 28'd150, 28'd5, 16'd0, 0, -1, "stop_below");
        run_sweep(28'd77, 28'd77, 28'd9, 16'd2, 0, -1, "stop_equal");
        run_sweep(28'd50, 28'd500, 28'd0, 16'd1, 0, -1, "step_zero");
    endtask

    task automatic test_carry;
        run_sweep(28'hFFFFFF0, 28'hFFFFFFF, 28'h10, 16'd1, 0, -1, "carry");
    endtask

    task automatic test_abort;
        run_sweep(28'd100, 28'd130, 28'd10, 16'd3, 0, 7, "abort");
        run_sweep(28'd100, 28'd130, 28'd10, 16'd3, 0, -1, "after_abort");
    endtask

    task automatic test_ce_toggle;
        run_sweep(28'd100, 28'd130, 28'd10, 16'd3, 1, -1, "ce_toggle");
    endtask

    task automatic test_start_abort_together;
        @(negedge CLK);
        START_INC = 28'd1; STOP_INC = 28'd5; STEP_INC = 28'd1; DWELL_CYCLES = 16'd1;
        CE = 1'b1; START = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if ({INC_WE, BUSY, DONE} !== 3'b000) begin
                failures++;
                $display("FAIL start_abort cyc=%0d we_busy_done got=%b exp=000", i, {INC_WE, BUSY, DONE});
            end
        end
    endtask

    task automatic test_reset_mid_dwell;
        @(negedge CLK);
        START_INC = 28'd100; STOP_INC = 28'd130; STEP_INC = 28'd10; DWELL_CYCLES = 16'd3;
        CE = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        checks++;
        if (BUSY !== 1'b1 || INC_OUT !== 28'd100) begin
            failures++;
            $display("FAIL pre_reset busy=%b inc_out=%0d exp busy=1 inc_out=100", BUSY, INC_OUT);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if ({INC_OUT, INC_WE, POINT_DONE, BUSY, DONE} !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {INC_OUT, INC_WE, POINT_DONE, BUSY, DONE});
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_inc = '0;
        @(posedge CLK);
        #1;
        checks++;
        if ({INC_WE, BUSY, DONE} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=000", {INC_WE, BUSY, DONE});
        end
        run_sweep(28'd100, 28'd130, 28'd10, 16'd3, 0, -1, "restart");
    endtask

    task automatic test_random;
        longint      s, st, e;
        logic [15:0] dw;
        for (int i = 0; i < 10; i++) begin
            s  = longint'($urandom_range(0, 32'h0FFFFFFF));
            st = ($urandom_range(0, 5) == 0) ? 0 : longint'($urandom_range(1, 50000));
            e  = s + st * longint'($urandom_range(0, 5));
            if (st > 0) e = e + longint'($urandom_range(0, 32'(st - 1)));
            if ($urandom_range(0, 4) == 0) e = s - longint'($urandom_range(1, 1000));
            if (e < 0) e = 0;
            if (e > 64'h0FFFFFFF) e = 64'h0FFFFFFF;
            dw = 16'($urandom_range(0, 4));
            run_sweep(28'(s), 28'(e), 28'(st), dw, (i % 2 == 0) ? 2 : 0, -1, "random");
        end
    endtask

    initial begin
        test_reset;
        test_sweep_basic;
        test_stop_below_start;
        test_carry;
        test_abort;
        test_ce_toggle;
        test_start_abort_together;
        test_reset_mid_dwell;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
